// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: multiply/divide op encodings,
// sequencer states and the default datapath width.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO architectural register pair. The result port wins over the MTHI/MTLO port.
module hilo_reg
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ResWe,
  input  logic [WIDTH-1:0] ResHi,
  input  logic [WIDTH-1:0] ResLo,
  input  logic             MtHiWe,
  input  logic             MtLoWe,
  input  logic [WIDTH-1:0] MtData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (ResWe) begin
      Hi <= ResHi;
      Lo <= ResLo;
    end else begin
      if (MtHiWe) Hi <= MtData;
      if (MtLoWe) Lo <= MtData;
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: WIDTH shift-add or restoring-divide
// steps on a shared 2*WIDTH accumulator, then sign fix-up into HI/LO.
module mult_div_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] MtData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e            state, state_nxt;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     opnd, a_orig;
  logic [CW-1:0]        count;
  logic                 is_div, neg_res, neg_rem, b_zero;
  logic                 done_q, dbz_q;

  logic                 idle, accept, last_step, in_signed, sa, sb, in_div;
  logic [WIDTH-1:0]     a_abs, b_abs, quo, rem, res_hi, res_lo;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   prod;

  assign idle      = (state == MD_IDLE);
  assign accept    = idle && Start;
  assign last_step = (count == CW'(WIDTH - 1));

  assign in_div    = Op[1];
  assign in_signed = ~Op[0];
  assign sa        = in_signed && A[WIDTH-1];
  assign sb        = in_signed && B[WIDTH-1];
  assign a_abs     = sa ? -A : A;
  assign b_abs     = sb ? -B : B;

  // Multiply adds the multiplicand into the upper half and shifts right;
  // divide shifts left and subtracts the divisor when it fits.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

  always_comb begin
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else                  acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign prod = neg_res ? -acc : acc;
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        res_hi = a_orig;
        res_lo = '1;
      end else begin
        res_hi = neg_rem ? -rem : rem;
        res_lo = neg_res ? -quo : quo;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (Start) state_nxt = MD_RUN;
      MD_RUN:  if (last_step) state_nxt = MD_FIX;
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc     <= '0;
      opnd    <= '0;
      a_orig  <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= (state == MD_FIX);
      dbz_q  <= (state == MD_FIX) && is_div && b_zero;
      if (accept) begin
        acc     <= {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
        opnd    <= in_div ? b_abs : a_abs;
        a_orig  <= A;
        count   <= '0;
        is_div  <= in_div;
        neg_res <= sa ^ sb;
        neg_rem <= sa;
        b_zero  <= (B == '0);
      end else if (state == MD_RUN) begin
        acc   <= acc_step;
        count <= count + CW'(1);
      end
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .Clk    (Clk),
    .Reset  (Reset),
    .ResWe  (state == MD_FIX),
    .ResHi  (res_hi),
    .ResLo  (res_lo),
    .MtHiWe (MtHi && idle && !Start),
    .MtLoWe (MtLo && idle && !Start),
    .MtData (MtData),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  assign Busy      = !idle;
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: vector table plus hand-written
// sequences for Mt writes, mid-run interference, reset and back-to-back issue.
module tb_mult_div_sequencer;
  import mips_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start, MtHi, MtLo;
  logic [1:0]   Op;
  logic [W-1:0] A, B, MtData;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Hi, Lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mult_div_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .MtHi(MtHi), .MtLo(MtLo), .MtData(MtData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
  endtask

  // Called at the negedge where Start was just driven; returns at the negedge Done is seen.
  task automatic wait_done(output int k, output int busy_cycles);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    k = 0; busy_cycles = 0;
    while (Done !== 1'b1 && k < 100) begin
      if (Busy) busy_cycles++;
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic no_done(input int n, input string name);
    int cnt = 0;
    repeat (n) begin
      @(negedge Clk);
      if (Done) cnt++;
    end
    chk(name, cnt, 0);
  endtask

  initial begin
    int k, bc;
    tv[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[3]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tv[4]  = '{MD_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
    tv[5]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tv[6]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tv[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tv[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tv[9]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    tv[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tv[11] = '{MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
    tv[12] = '{MD_MULT,  32'hFFFFFFFD, 32'd0,        32'h00000000, 32'h00000000, 1'b0};
    tv[13] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};
    tv[14] = '{MD_MULTU, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0};

    Reset = 1'b1; Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    Op = '0; A = '0; B = '0; MtData = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_dbz", DivByZero, 0);
    chk("reset_hi", Hi, 0);
    chk("reset_lo", Lo, 0);

    // Mt writes in IDLE, one-edge latency
    MtHi = 1'b1; MtData = 32'hCAFEF00D;
    @(negedge Clk);
    MtHi = 1'b0;
    chk("mthi", Hi, 32'hCAFEF00D);
    MtLo = 1'b1; MtData = 32'h13579BDF;
    @(negedge Clk);
    MtLo = 1'b0;
    chk("mtlo", Lo, 32'h13579BDF);
    chk("mtlo_hi_kept", Hi, 32'hCAFEF00D);

    // Start together with Mt writes: Mt dropped; then reset at count=10
    MtHi = 1'b1; MtLo = 1'b1; MtData = 32'hDEADBEEF;
    issue(MD_MULTU, 32'd3, 32'd5);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    chk("start_wins_hi", Hi, 32'hCAFEF00D);
    chk("start_wins_lo", Lo, 32'h13579BDF);
    repeat (10) @(posedge Clk);
    #2;
    chk("busy_before_reset", Busy, 1);
    Reset = 1'b1;
    #1;
    chk("midreset_busy", Busy, 0);
    chk("midreset_hi", Hi, 0);
    chk("midreset_lo", Lo, 0);
    chk("midreset_done", Done, 0);
    @(negedge Clk);
    Reset = 1'b0;
    no_done(40, "no_done_after_reset");

    // Vector table
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      issue(tv[i].op, tv[i].a, tv[i].b);
      wait_done(k, bc);
      chk($sformatf("v%0d_latency", i), k, 33);
      chk($sformatf("v%0d_busy_cycles", i), bc, 33);
      chk($sformatf("v%0d_busy_at_done", i), Busy, 0);
      chk($sformatf("v%0d_hi", i), Hi, tv[i].hi);
      chk($sformatf("v%0d_lo", i), Lo, tv[i].lo);
      chk($sformatf("v%0d_dbz", i), DivByZero, tv[i].dbz);
    end

    // Back-to-back: new Start accepted while Done is high
    issue(MD_MULTU, 32'd6, 32'd7);
    wait_done(k, bc);
    chk("b2b_latency", k, 33);
    chk("b2b_lo", Lo, 32'd42);
    chk("b2b_hi", Hi, 32'd0);
    @(negedge Clk);
    chk("done_one_cycle", Done, 0);

    // MtLo and Start during RUN are ignored
    MtLo = 1'b1; MtData = 32'h11111111;
    @(negedge Clk);
    MtLo = 1'b0;
    chk("mtlo_pre", Lo, 32'h11111111);
    issue(MD_MULTU, 32'd3, 32'd5);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    MtLo = 1'b1; MtData = 32'h22222222;
    issue(MD_DIVU, 32'd9, 32'd3);
    @(negedge Clk);
    MtLo = 1'b0; Start = 1'b0;
    chk("midrun_mtlo_lo", Lo, 32'h11111111);
    chk("midrun_busy", Busy, 1);
    k = 0;
    while (Done !== 1'b1 && k < 100) begin
      @(negedge Clk);
      k++;
    end
    chk("midrun_done_seen", Done, 1);
    chk("midrun_result_lo", Lo, 32'd15);
    chk("midrun_result_hi", Hi, 32'd0);
    no_done(40, "no_extra_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
